riscv_test_harness_ctrl: RTL
============================

Name: riscv_test_harness_ctrl

Overview:
Synthesisable controller for running riscv-tests ISA programs (rv32ui-p-*) on Core, in simulation or on FPGA. It replaces fixed tick-count benches with these features:
- programmable core reset sequencing;
- a watchdog;
- pass/fail detection from tohost stores or ECALL-with-gp;
- cycle and retire counters.
It sits beside Core: it drives Core's reset input and observes Core's store and retire ports.

Parameters:
XLEN, 32, data/address width of observed buses.
RESET_CYCLES, 1, cycles core_rst held high after start (≥1).
MAX_TICKS, 5000, watchdog limit in RUN cycles; 0 disables the watchdog.
TOHOST_ADDR, 32'h0000_1000, byte address of the tohost word.
CNT_W, 32, width of cycle_count and retire_count.
AUTO_START, 1, 1 = leave IDLE on the first cycle after rst deasserts; 0 = wait for start.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  begin a run from IDLE (used only when AUTO_START=0).
mem_we  in  1  Core data-store strobe.
mem_addr  in  XLEN  Core store byte address.
mem_wdata  in  XLEN  Core store data.
retire_valid  in  1  one instruction retired this cycle.
retire_ecall  in  1  retiring instruction is ECALL (qualified by retire_valid).
gp_value  in  XLEN  current x3 (gp) value.
core_rst  out  1  reset to Core, active high.
running  out  1  state == RUN.
done  out  1  run finished (sticky).
pass  out  1  test passed (valid when done).
timeout  out  1  watchdog expired (valid when done).
fail_num  out  XLEN  failing TESTNUM; 0 on pass or timeout.
cycle_count  out  CNT_W  RUN cycles elapsed.
retire_count  out  CNT_W  instructions retired in RUN.

Behaviour:
- All outputs are registered.
- rst is synchronous, active-high, and overrides everything. On reset:
  - state = IDLE;
  - core_rst = 1;
  - running, done, pass, timeout = 0;
  - fail_num, cycle_count, retire_count = 0.
- Asserting rst mid-run aborts the run and reasserts core_rst on the next edge.
- FSM states: IDLE, CRST, RUN, DONE.
- IDLE:
  - core_rst = 1.
  - Go to CRST when AUTO_START=1, or when start=1 with AUTO_START=0.
  - start is ignored in every other state.
- CRST:
  - core_rst = 1 for exactly RESET_CYCLES cycles; an internal down-counter is loaded on entry.
  - Then go to RUN, with core_rst = 0 and running = 1 on the same edge.
- RUN:
  - cycle_count = 0 in the first RUN cycle and increments by 1 on every RUN edge; it saturates at all-ones.
  - retire_count increments on each retire_valid; it saturates.
  - Events are sampled on the current cycle's inputs, in priority order:
    1. Tohost event: mem_we && mem_addr == TOHOST_ADDR && mem_wdata[0] == 1.
       - mem_wdata == 1 → pass.
       - Otherwise → fail, with fail_num = mem_wdata >> 1.
       - A tohost store with bit0 == 0 is ignored and the run continues.
    2. ECALL event: retire_valid && retire_ecall.
       - gp_value == 1 → pass.
       - Otherwise → fail, with fail_num = gp_value >> 1.
    3. Watchdog: MAX_TICKS != 0 && cycle_count == MAX_TICKS-1 → timeout = 1, pass = 0, fail_num = 0.
  - Any event moves to DONE on that edge. done/pass/timeout/fail_num are visible on the following cycle.
  - A result event in the same cycle as watchdog expiry counts as a result, not a timeout.
  - The event cycle's retire is still counted. cycle_count freezes at its event-cycle value + 1.
- DONE:
  - core_rst = 1, holding Core quiescent.
  - running = 0.
  - done and result outputs are sticky and counters are frozen until rst.
  - All further inputs are ignored.
- Invariant: pass and timeout are never both 1. fail_num != 0 only when done && !pass && !timeout.

Test Plan:
1. Defaults, rst high for 2 cycles then low:
   - core_rst = 1 through the first post-reset cycle (IDLE) plus 1 CRST cycle, then 0;
   - running rises on the same edge;
   - cycle_count = 0 in the first RUN cycle.
2. Tohost pass: at cycle_count = 37, drive mem_we = 1, mem_addr = 32'h1000, mem_wdata = 1, with retire_valid for 30 of those cycles:
   - next cycle: done = 1, pass = 1, fail_num = 0, cycle_count = 38, retire_count = 30;
   - all of these hold for 100 more cycles.
3. ECALL fail: retire_valid = 1, retire_ecall = 1, gp_value = 32'h0000_0007 → done = 1, pass = 0, fail_num = 3, timeout = 0.
4. Tohost store with mem_wdata = 32'h10 → ignored, running stays 1. Then ECALL with gp = 1 → pass = 1.
5. MAX_TICKS = 20, no events → done = 1 and timeout = 1 the cycle after cycle_count = 19. Repeat with a tohost pass at cycle_count = 19 → pass = 1, timeout = 0.
6. AUTO_START = 0, RESET_CYCLES = 4:
   - idles with core_rst = 1 until a start pulse, then 4 CRST cycles, then RUN.
   - Assert rst at cycle_count = 10 → next edge: IDLE, core_rst = 1, counters = 0.

Source files
------------

// File: rtl/riscv_test_harness_ctrl.sv
// riscv_test_harness_ctrl: sequences Core reset, watches tohost/ECALL for pass/fail, runs a watchdog and counters
module riscv_test_harness_ctrl #(
  parameter int              XLEN         = 32,
  parameter int              RESET_CYCLES = 1,
  parameter int              MAX_TICKS    = 5000,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'h0000_1000,
  parameter int              CNT_W        = 32,
  parameter int              AUTO_START   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  input  logic             retire_valid,
  input  logic             retire_ecall,
  input  logic [XLEN-1:0]  gp_value,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [XLEN-1:0]  fail_num,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
);
  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((MAX_TICKS == 0) ? 0 : MAX_TICKS - 1);

  typedef enum logic [1:0] {IDLE, CRST, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic              core_rst_q, core_rst_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [XLEN-1:0]   fail_q, fail_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  retire_q, retire_d;
  logic              tohost_ev, ecall_ev, wd_ev;

  assign core_rst     = core_rst_q;
  assign running      = running_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign fail_num     = fail_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;

  // state and registered outputs; rst returns to IDLE with Core held in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rcnt_q     <= '0;
      core_rst_q <= 1'b1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      fail_q     <= '0;
      cycle_q    <= '0;
      retire_q   <= '0;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      core_rst_q <= core_rst_d;
      running_q  <= running_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      fail_q     <= fail_d;
      cycle_q    <= cycle_d;
      retire_q   <= retire_d;
    end
  end

  // next state: reset sequencing, saturating counters, and prioritised result capture (tohost > ECALL > watchdog)
  always_comb begin
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    core_rst_d = core_rst_q;
    running_d  = running_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    fail_d     = fail_q;
    cycle_d    = cycle_q;
    retire_d   = retire_q;
    tohost_ev  = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
    ecall_ev   = retire_valid && retire_ecall;
    wd_ev      = (MAX_TICKS != 0) && (cycle_q == WD_LAST);
    case (state_q)
      IDLE: begin
        if ((AUTO_START != 0) || start) begin
          state_d = CRST;
          rcnt_d  = RW'(RESET_CYCLES - 1);
        end
      end
      CRST: begin
        if (rcnt_q == '0) begin
          state_d    = RUN;
          core_rst_d = 1'b0;
          running_d  = 1'b1;
          cycle_d    = '0;
          retire_d   = '0;
        end else begin
          rcnt_d = rcnt_q - RW'(1);
        end
      end
      RUN: begin
        cycle_d  = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);
        retire_d = (retire_valid && !(&retire_q)) ? retire_q + CNT_W'(1) : retire_q;
        if (tohost_ev || ecall_ev || wd_ev) begin
          state_d    = DONE;
          core_rst_d = 1'b1;
          running_d  = 1'b0;
          done_d     = 1'b1;
        end
        if (tohost_ev) begin
          pass_d = (mem_wdata == XLEN'(1));
          fail_d = mem_wdata >> 1;
        end else if (ecall_ev) begin
          pass_d = (gp_value == XLEN'(1));
          fail_d = gp_value >> 1;
        end else if (wd_ev) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          fail_d    = '0;
        end
      end
      default: ;
    endcase
  end
endmodule
